// File: rtl/pueo_trig_sched.sv
// pueo_trig_sched: queues trigger times and turns each into a run of signal-buffer row reads into a free event slot.
// Optional trigger spacing check is enabled by defining PUEO_TRIG_SCHED_HOLDOFF_EN.
module pueo_trig_sched #(
    parameter int TRIGBIT   = 15,
    parameter int ADDRBIT   = 12,
    parameter int OFFSET    = 64,
    parameter int NROW      = 128,
    parameter int NSLOT     = 4,
    parameter int FIFODEPTH = 16,
    parameter int HOLDOFF   = 256
) (
    input  logic                         memclk_i,
    input  logic                         memclk_rst_i,
    input  logic                         run_i,
    input  logic [TRIGBIT-1:0]           trig_time_i,
    input  logic                         trig_valid_i,
    output logic [ADDRBIT-1:0]           rd_addr_o,
    output logic [$clog2(NSLOT)-1:0]     rd_slot_o,
    output logic                         rd_valid_o,
    output logic                         rd_last_o,
    input  logic                         rd_ready_i,
    input  logic [NSLOT-1:0]             slot_done_i,
    output logic [NSLOT-1:0]             slot_busy_o,
    output logic [$clog2(FIFODEPTH):0]   queue_count_o,
    output logic [15:0]                  drop_count_o,
    output logic                         busy_o
);
    localparam int SW = $clog2(NSLOT);
    localparam int FW = $clog2(FIFODEPTH);
    localparam int RW = (NROW > 1) ? $clog2(NROW) : 1;

    typedef enum logic [1:0] {IDLE, ALLOC, READ} state_t;

    state_t             state, state_nx;
    logic [ADDRBIT-1:0] mem [FIFODEPTH];
    logic [FW-1:0]      wp, rp;
    logic [FW:0]        cnt;
    logic [RW-1:0]      row;
    logic [NSLOT-1:0]   busy;
    logic [ADDRBIT-1:0] addr;
    logic [SW-1:0]      slot, free_idx;
    logic [15:0]        drops;
    logic               free, pop, push, drop, trig, hold_ok, full;
    logic               unused_hi;

    assign unused_hi = ^trig_time_i[TRIGBIT-1:ADDRBIT];

    // lowest-index free slot
    always_comb begin
        free = 1'b0;
        free_idx = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free = 1'b1;
                free_idx = SW'(i);
            end
        end
    end

    assign full = cnt == (FW+1)'(FIFODEPTH);
    assign pop  = state == ALLOC && free;
    assign trig = trig_valid_i && run_i;
    assign push = trig && hold_ok && (!full || pop);
    assign drop = trig && !push;

`ifdef PUEO_TRIG_SCHED_HOLDOFF_EN
    localparam int HW = $clog2(HOLDOFF + 1);
    logic [HW-1:0] hold;
    // cycles remaining before another trigger may be accepted
    always_ff @(posedge memclk_i) begin
        if (memclk_rst_i || !run_i) hold <= '0;
        else if (push) hold <= HW'(HOLDOFF - 1);
        else if (hold != '0) hold <= hold - 1'b1;
    end
    assign hold_ok = hold == '0;
`else
    assign hold_ok = 1'b1;
`endif

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (cnt != '0) state_nx = ALLOC;
            ALLOC:   if (free) state_nx = READ;
            READ:    if (rd_ready_i && row == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // queue storage holds only start addresses; left unreset
    always_ff @(posedge memclk_i) begin
        if (push) mem[wp] <= trig_time_i[ADDRBIT-1:0] - ADDRBIT'(OFFSET);
    end

    // control state, queue pointers, slot occupancy and read counters; stopping the run clears everything
    always_ff @(posedge memclk_i) begin
        if (memclk_rst_i || !run_i) begin
            state <= IDLE;
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            busy  <= '0;
            addr  <= '0;
            slot  <= '0;
            row   <= '0;
            drops <= '0;
        end else begin
            state <= state_nx;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt   <= cnt + (FW+1)'(push) - (FW+1)'(pop);
            busy  <= (busy & ~slot_done_i) | (pop ? NSLOT'(1) << free_idx : '0);
            if (drop && drops != 16'hFFFF) drops <= drops + 1'b1;
            if (pop) begin
                addr <= mem[rp];
                slot <= free_idx;
                row  <= RW'(NROW - 1);
            end else if (state == READ && rd_ready_i) begin
                addr <= addr + 1'b1;
                row  <= row - 1'b1;
            end
        end
    end

    assign rd_valid_o    = state == READ;
    assign rd_last_o     = state == READ && row == '0;
    assign rd_addr_o     = addr;
    assign rd_slot_o     = slot;
    assign slot_busy_o   = busy;
    assign queue_count_o = cnt;
    assign drop_count_o  = drops;
    assign busy_o        = state != IDLE || cnt != '0;
endmodule

// File: tb/tb_pueo_trig_sched.sv
// tb_pueo_trig_sched: directed vector bench for the trigger readout scheduler.
module tb_pueo_trig_sched;
    logic        clk = 1'b0;
    logic        rst, run, trig_valid, rd_ready, rd_valid, rd_last, busy;
    logic [14:0] trig_time;
    logic [11:0] rd_addr;
    logic [1:0]  rd_slot;
    logic [3:0]  slot_done, slot_busy;
    logic [4:0]  queue_count;
    logic [15:0] drop_count;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [14:0] t;
        logic [11:0] start;
        int          slot;
        logic [3:0]  pre_done;
        logic [3:0]  busy_after;
    } vec_t;

    vec_t tbl [5];

    pueo_trig_sched dut (
        .memclk_i      (clk),
        .memclk_rst_i  (rst),
        .run_i         (run),
        .trig_time_i   (trig_time),
        .trig_valid_i  (trig_valid),
        .rd_addr_o     (rd_addr),
        .rd_slot_o     (rd_slot),
        .rd_valid_o    (rd_valid),
        .rd_last_o     (rd_last),
        .rd_ready_i    (rd_ready),
        .slot_done_i   (slot_done),
        .slot_busy_o   (slot_busy),
        .queue_count_o (queue_count),
        .drop_count_o  (drop_count),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input logic [3:0] m);
        slot_done = m;
        tick();
        slot_done = '0;
    endtask

    task automatic strobe(input logic [14:0] t);
        trig_time  = t;
        trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
    endtask

    task automatic read_rows(input logic [11:0] start, input int s, input int n);
        logic [11:0] a;
        for (int r = 0; r < n; r++) begin
            a = start + 12'(r);
            chk("rd_valid", rd_valid, 1);
            chk("rd_addr", rd_addr, a);
            chk("rd_slot", rd_slot, s);
            chk("rd_last", rd_last, r == 127);
            tick();
        end
    endtask

    initial begin
        int lasts;
        tbl[0] = '{15'h0040, 12'h000, 0, 4'b0000, 4'b0001};
        tbl[1] = '{15'h0010, 12'hFD0, 1, 4'b0000, 4'b0011};
        tbl[2] = '{15'h7FFF, 12'hFBF, 2, 4'b0000, 4'b0111};
        tbl[3] = '{15'h1234, 12'h1F4, 3, 4'b0000, 4'b1111};
        tbl[4] = '{15'h0000, 12'hFC0, 0, 4'b0001, 4'b1111};
        rst = 1'b1; run = 1'b0; trig_valid = 1'b0; trig_time = '0; rd_ready = 1'b1; slot_done = '0;
        repeat (3) tick();
        chk("rst rd_valid", rd_valid, 0);
        chk("rst rd_last", rd_last, 0);
        chk("rst rd_addr", rd_addr, 0);
        chk("rst rd_slot", rd_slot, 0);
        chk("rst slot_busy", slot_busy, 0);
        chk("rst queue_count", queue_count, 0);
        chk("rst drop_count", drop_count, 0);
        chk("rst busy", busy, 0);
        rst = 1'b0; run = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].pre_done != '0) pulse_done(tbl[i].pre_done);
            strobe(tbl[i].t);
            chk("queued T+1", queue_count, 1);
            chk("no valid T+1", rd_valid, 0);
            tick();
            chk("no valid T+2", rd_valid, 0);
            tick();
            read_rows(tbl[i].start, tbl[i].slot, 128);
            chk("valid drops after last", rd_valid, 0);
            chk("slot_busy after event", slot_busy, tbl[i].busy_after);
        end

        strobe(15'h0050);
        repeat (10) tick();
        chk("alloc wait rd_valid", rd_valid, 0);
        chk("alloc wait queue_count", queue_count, 1);
        chk("alloc wait busy", busy, 1);
        pulse_done(4'b0100);
        chk("done clears busy bit", slot_busy, 4'b1011);
        chk("done cycle rd_valid", rd_valid, 0);
        tick();
        read_rows(12'h010, 2, 128);
        chk("slot 2 reused busy", slot_busy, 4'b1111);
        chk("queue drained", queue_count, 0);

        for (int i = 0; i < 20; i++) strobe(15'h0040);
        chk("overflow queue_count", queue_count, 16);
        chk("overflow drop_count", drop_count, 4);
        chk("overflow busy", busy, 1);
        pulse_done(4'b0010);
        chk("slot 1 freed", slot_busy, 4'b1101);
        tick();
        chk("popped queue_count", queue_count, 15);
        read_rows(12'h000, 1, 10);
        run = 1'b0;
        tick();
        chk("abort rd_valid", rd_valid, 0);
        chk("abort rd_last", rd_last, 0);
        chk("abort rd_addr", rd_addr, 0);
        chk("abort slot_busy", slot_busy, 0);
        chk("abort queue_count", queue_count, 0);
        chk("abort drop_count", drop_count, 0);
        chk("abort busy", busy, 0);
        run = 1'b1;
        tick();
        strobe(15'h0040);
        tick();
        tick();
        read_rows(12'h000, 0, 128);

        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        lasts = 0;
        trig_time = 15'h0040;
        for (int c = 0; c < 700; c++) begin
            trig_valid = (c == 0 || c == 100 || c == 300);
            if (rd_valid && rd_ready && rd_last) lasts++;
            tick();
        end
        trig_valid = 1'b0;
`ifdef PUEO_TRIG_SCHED_HOLDOFF_EN
        chk("spacing drop_count", drop_count, 1);
        chk("spacing events", lasts, 2);
        chk("spacing slot_busy", slot_busy, 4'b0011);
`else
        chk("spacing drop_count", drop_count, 0);
        chk("spacing events", lasts, 3);
        chk("spacing slot_busy", slot_busy, 4'b0111);
`endif
        chk("spacing idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pueo_trig_sched.md
# pueo_trig_sched

Trigger readout scheduler between the command decoder and the signal buffer / event buffer pair, running in the memory clock domain. It queues incoming trigger times and converts each into a run of consecutive signal-buffer row read requests. It assigns each trigger a free event-buffer slot and releases slots when the event buffer reports them drained. A run control clears queue, slots and counters on stop.

## Interface
- `TRIGBIT`, 15: trigger time width.
- `ADDRBIT`, 12: signal buffer row address width.
- `OFFSET`, 64: rows subtracted from the trigger time to form the start address (pretrigger).
- `NROW`, 128: rows read per trigger.
- `NSLOT`, 4: event buffer slots; power of 2, at most 8.
- `FIFODEPTH`, 16: trigger queue depth; power of 2.
- `HOLDOFF`, 256: minimum accepted-trigger spacing in cycles; used only with the configuration macro.

Ports:
- `memclk_i` in 1: memory clock.
- `memclk_rst_i` in 1: reset, synchronous, active-high.
- `run_i` in 1: level; 1 = accept and schedule triggers.
- `trig_time_i` in TRIGBIT: trigger time.
- `trig_valid_i` in 1: single-cycle trigger strobe.
- `rd_addr_o` out ADDRBIT: row read address.
- `rd_slot_o` out $clog2(NSLOT): destination slot.
- `rd_valid_o` out 1: read request valid.
- `rd_last_o` out 1: final row of the event.
- `rd_ready_i` in 1: read request accepted when high with `rd_valid_o`.
- `slot_done_i` in NSLOT: one-hot pulse; the slot has been drained.
- `slot_busy_o` out NSLOT: slot occupancy.
- `queue_count_o` out $clog2(FIFODEPTH)+1: queued triggers.
- `drop_count_o` out 16: dropped triggers, saturating.
- `busy_o` out 1: FSM not IDLE or queue non-empty.

## Operation
- Start address is `trig_time_i[ADDRBIT-1:0] - OFFSET` mod 2^ADDRBIT, computed at enqueue.
- Only the start address is stored; `trig_time_i` upper bits are ignored.
- Enqueue occurs when `trig_valid_i & run_i` and the queue is not full.
  - If the queue is full, the trigger is dropped and `drop_count_o` increments, saturating at 0xFFFF.
  - `trig_valid_i` while `run_i`=0 is ignored and not counted.
- FSM states: IDLE, ALLOC, READ.
  - IDLE -> ALLOC when the queue is non-empty.
  - ALLOC: wait until any slot is free, take the lowest-index free slot, set its busy bit, pop the queue, load the address counter and row counter = NROW-1, then -> READ.
  - READ: `rd_valid_o`=1. On each `rd_ready_i`, the address increments mod 2^ADDRBIT (wraps 0xFFF->0x000) and the row counter decrements.
  - `rd_last_o`=1 when the row counter = 0; the handshake on that row -> IDLE.
- `rd_valid_o`, `rd_addr_o`, `rd_slot_o` and `rd_last_o` stay stable while `rd_valid_o` is high and `rd_ready_i` is low.
- Slot release: a `slot_done_i` bit clears the matching busy bit.
  - A done for a non-busy slot is ignored.
  - A same-cycle allocate and done on the same slot: done wins only if the slot was already busy. Allocation never targets a busy slot, so there is no conflict.
- `run_i` falling: synchronously returns to IDLE in the next cycle.
  - The queue, all busy bits and `drop_count_o` are cleared.
  - A READ in progress is aborted; `rd_valid_o` drops without `rd_last_o`.
  - `run_i` rising starts from empty state.
- Enqueue and dequeue in the same cycle leave `queue_count_o` unchanged; a full queue may accept in a cycle it pops.

## Timing
- Reset values: `rd_valid_o`=0, `rd_last_o`=0, `rd_addr_o`=0, `rd_slot_o`=0, `slot_busy_o`=0, `queue_count_o`=0, `drop_count_o`=0, `busy_o`=0. FSM = IDLE.
- Trigger at cycle T (empty queue, free slot, running):
  - queued at T+1;
  - ALLOC at T+2;
  - first `rd_valid_o` at T+3.
- With `rd_ready_i` held high, one row per cycle: last row at T+3+NROW-1, back in IDLE the next cycle. Back-to-back events therefore carry a 2-cycle gap.
- `slot_done_i` at cycle D: busy bit clear at D+1; usable by ALLOC at D+1.
- `run_i` low at cycle R: all state cleared and outputs at reset values at R+1.

## Configuration
- `PUEO_TRIG_SCHED_HOLDOFF_EN` defined:
  - A trigger arriving fewer than HOLDOFF cycles after the previous accepted trigger is dropped and counted in `drop_count_o`.
  - The holdoff counter starts at acceptance, is cleared by reset and `run_i` low, and the first trigger after run start is always eligible.
- Undefined: no spacing check; only queue-full drops are counted.

## Test plan
- Single trigger, time 0x0040, defaults, ready high -> 128 requests with addresses 0x000..0x07F, slot 0, `rd_last_o` on 0x07F; first valid 3 cycles after the strobe.
- Trigger time 0x0010 -> addresses 0xFD0..0xFFF then 0x000..0x04F (wrap), 128 total.
- Five triggers with no `slot_done_i` -> slots 0,1,2,3 used; fifth waits in ALLOC; pulse `slot_done_i`=4'b0100 -> fifth is read into slot 2.
- 20 triggers in consecutive cycles, slots all busy -> `queue_count_o`=16, `drop_count_o`=4.
- `run_i` dropped mid-READ after 10 rows -> next cycle: `rd_valid_o`=0, `slot_busy_o`=0, `queue_count_o`=0, `drop_count_o`=0.
- Macro defined, HOLDOFF=256, triggers at cycles 0, 100, 300 -> the cycle-100 trigger is dropped and counted; 0 and 300 are scheduled. Macro undefined -> all three are scheduled.
